addsub_nibble_seq: RTL and testbench
====================================

Name: addsub_nibble_seq

Overview:
- Multi-cycle WIDTH-bit signed add/subtract unit.
- Processes one 4-bit nibble per clock through a single internal 4-bit add/sub slice with a registered carry between nibbles.
- Sits beside the ALU as the area-reduced arithmetic path: one shared nibble adder, sequenced least-significant nibble first.
- Simple start/busy/done handshake with the issuing control logic.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be a multiple of 4 and at least 8. NSTEPS = WIDTH/4.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, two's complement; sampled on accepted start.
- b  input  WIDTH  operand B, two's complement; sampled on accepted start.
- sub  input  1  0 = A+B, 1 = A-B; sampled on accepted start.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result register.
- ovfl  output  1  signed overflow of the full-width operation.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH-1].

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- rst_n low, at any time including mid-RUN:
  - Immediately: state = IDLE, nibble index = 0, carry = 0.
  - busy, done, sum, ovfl, zero, neg all = 0.
  - Latched operands are discarded.
- States: IDLE, RUN, DONE.
- IDLE, start=1, on the edge:
  - Latch a into A_r.
  - Latch B_r = sub ? ~b : b.
  - carry = sub.
  - idx = 0; go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - nibble = A_r[4*idx+3:4*idx] + B_r[4*idx+3:4*idx] + carry, 5-bit result.
  - sum[4*idx+3:4*idx] is written with the low 4 bits; carry is updated from bit 4.
  - Nibbles of sum not yet written hold the previous result until overwritten.
  - On the edge with idx == NSTEPS-1:
    - Compute ovfl = (A_r msb == B_r msb) && (final sum msb != A_r msb).
    - Compute zero and neg from the final sum.
    - Go to DONE: done=1, busy=0.
  - Otherwise idx increments.
- DONE: lasts exactly one cycle. If start=1, it behaves as the IDLE start edge (back-to-back accepted); otherwise go to IDLE.
- Latency: start accepted on edge E0. Nibbles are processed on edges E1..E_NSTEPS. done is high for the single cycle after E_NSTEPS. For WIDTH=16, busy is high for 4 cycles.
- start while RUN is ignored. Input changes while RUN have no effect.
- sum, ovfl, zero and neg hold their final values through DONE and IDLE until the next start is accepted.
- zero and neg are meaningful only when done is high or later; during RUN they hold the previous result's values.
- Carry out of the top nibble is discarded (not a port). Wrap-around is modulo 2^WIDTH.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when ovfl=1 on the final nibble, sum is forced on that same edge to:
  - 0x7FFF… (max positive) if A_r msb = 0;
  - 0x800… (min negative) if A_r msb = 1.
  - ovfl is still reported as 1.
  - zero and neg are derived from the saturated value.
- Undefined: sum is the wrapped modulo result; no forcing logic is present.

Test Plan (WIDTH=16):
- a=0x1234, b=0x1111, sub=0, start for 1 cycle -> busy high exactly 4 cycles; done pulses 1 cycle later with sum=0x2345, ovfl=0, zero=0, neg=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovfl=1, neg=1. With ADDSUB_SATURATE_EN: sum=0x7FFF, neg=0.
- a=0x0005, b=0x0005, sub=1 -> sum=0x0000, zero=1, ovfl=0.
- a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovfl=1. With saturation: sum=0x8000, neg=1.
- Op a=0x00FF, b=0x0001, sub=0; pulse start again during RUN with a=0xAAAA -> second start ignored; sum=0x0100.
- Back-to-back: hold start high during the done cycle with a=0x0010, b=0x0001, sub=1 -> accepted; next done 5 cycles after the first done, sum=0x000F.
- Drop rst_n mid-RUN (after 2 nibbles) -> all outputs 0 without a clock edge; after release, a=0x0F0F + b=0x0101 -> sum=0x1010.

Source files
------------

// File: rtl/addsub_nibble_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | addsub_nibble_seq_if : start/busy/done handshake bundle for the nibble   |
// | add/sub unit.                                          Revision: 1.0     |
// +--------------------------------------------------------------------------+
interface addsub_nibble_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             ovfl;
   logic             zero;
   logic             neg;

   modport master (
      output start, a, b, sub,
      input  busy, done, sum, ovfl, zero, neg
   );

   modport slave (
      input  start, a, b, sub,
      output busy, done, sum, ovfl, zero, neg
   );
endinterface
`default_nettype wire

// File: rtl/addsub_nibble_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | addsub_nibble_seq : multi-cycle signed add/sub, one 4-bit nibble per     |
// | clock, LSB nibble first. Option macro: ADDSUB_SATURATE_EN. Revision: 1.0 |
// +--------------------------------------------------------------------------+
module addsub_nibble_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   addsub_nibble_seq_if.slave bus
);
   localparam int NSTEPS = WIDTH / 4;
   localparam int IDXW   = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

   localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_accept;
   logic             w_busy;
   logic             w_done;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [IDXW-1:0]  r_idx;
   logic [WIDTH-1:0] r_sum;
   logic             r_ovfl;
   logic             r_zero;
   logic             r_neg;

   logic             w_last;
   logic [4:0]       w_nib;
   logic [WIDTH-1:0] w_sum_next;
   logic [WIDTH-1:0] w_sum_final;
   logic             w_ovfl;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept     = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            w_busy = 1'b1;
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            if (bus.start) begin
               w_accept     = 1'b1;
               w_state_next = S_RUN;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ---------------- shared nibble slice ----------------
   assign w_last = (r_idx == IDXW'(NSTEPS - 1));
   assign w_nib  = {1'b0, r_a[4*r_idx +: 4]} + {1'b0, r_b[4*r_idx +: 4]} + {4'd0, r_carry};

   always_comb begin
      w_sum_next                = r_sum;
      w_sum_next[4*r_idx +: 4]  = w_nib[3:0];
   end

   // B has already been inverted for subtraction, so this is the plain add rule
   assign w_ovfl = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);

   always_comb begin
      w_sum_final = w_sum_next;
`ifdef ADDSUB_SATURATE_EN
      if (w_last && w_ovfl) begin
         w_sum_final = r_a[WIDTH-1] ? c_min_neg : c_max_pos;
      end
`endif
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_ovfl  <= 1'b0;
         r_zero  <= 1'b0;
         r_neg   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.sub ? ~bus.b : bus.b;
         r_carry <= bus.sub;
         r_idx   <= '0;
      end else if (r_state == S_RUN) begin
         r_sum   <= w_sum_final;
         r_carry <= w_nib[4];
         if (w_last) begin
            r_ovfl <= w_ovfl;
            r_zero <= (w_sum_final == '0);
            r_neg  <= w_sum_final[WIDTH-1];
         end else begin
            r_idx  <= r_idx + IDXW'(1);
         end
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;
   assign bus.sum  = r_sum;
   assign bus.ovfl = r_ovfl;
   assign bus.zero = r_zero;
   assign bus.neg  = r_neg;

   // c_max_pos/c_min_neg are referenced only in the saturating build
   logic w_unused_consts;
   assign w_unused_consts = ^{c_max_pos, c_min_neg};
endmodule
`default_nettype wire

// File: tb/tb_addsub_nibble_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_addsub_nibble_seq : directed vectors with a result scoreboard for     |
// | addsub_nibble_seq (WIDTH=16).                          Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_addsub_nibble_seq;
   logic clk;
   logic rst_n;

   addsub_nibble_seq_if #(.WIDTH(16)) bus ();

   addsub_nibble_seq #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] sum;
      logic        ovfl;
      logic        zero;
      logic        neg;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: pops one expected result per done pulse
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sum",  {16'd0, bus.sum}, {16'd0, e.sum});
            check("ovfl", {31'd0, bus.ovfl}, {31'd0, e.ovfl});
            check("zero", {31'd0, bus.zero}, {31'd0, e.zero});
            check("neg",  {31'd0, bus.neg},  {31'd0, e.neg});
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
      check({tag, "_sum"},  {16'd0, bus.sum},  32'd0);
      check({tag, "_ovfl"}, {31'd0, bus.ovfl}, 32'd0);
      check({tag, "_zero"}, {31'd0, bus.zero}, 32'd0);
      check({tag, "_neg"},  {31'd0, bus.neg},  32'd0);
   endtask

   // One operation; poke=1 re-pulses start with new A while the unit is running
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input exp_t e, input bit poke);
      int n;
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = s;
      sb.push_back(e);
      @(negedge clk);
      bus.start = poke;
      if (poke) bus.a = 16'hAAAA;
      n = 0;
      while (!bus.done && n < 20) begin
         if (bus.busy) n++;
         @(negedge clk);
         bus.start = 1'b0;
      end
      check("done_seen", {31'd0, bus.done}, 32'd1);
      check("busy_cycles", n, 32'd4);
      @(negedge clk);
      check("done_pulse", {31'd0, bus.done}, 32'd0);
      check("sum_hold", {16'd0, bus.sum}, {16'd0, e.sum});
   endtask

   initial begin
      int n;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      do_op(16'h1234, 16'h1111, 1'b0, '{16'h2345, 1'b0, 1'b0, 1'b0}, 1'b0);
`ifdef ADDSUB_SATURATE_EN
      do_op(16'h7FFF, 16'h0001, 1'b0, '{16'h7FFF, 1'b1, 1'b0, 1'b0}, 1'b0);
`else
      do_op(16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b1, 1'b0, 1'b1}, 1'b0);
`endif

      // Abort mid-run: outputs must clear without any clock edge
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1111; bus.sub = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      do_op(16'h0F0F, 16'h0101, 1'b0, '{16'h1010, 1'b0, 1'b0, 1'b0}, 1'b0);

      do_op(16'h0005, 16'h0005, 1'b1, '{16'h0000, 1'b0, 1'b1, 1'b0}, 1'b0);
`ifdef ADDSUB_SATURATE_EN
      do_op(16'h8000, 16'h0001, 1'b1, '{16'h8000, 1'b1, 1'b0, 1'b1}, 1'b0);
`else
      do_op(16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b0, 1'b0}, 1'b0);
`endif
      do_op(16'h0003, 16'h0005, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b1}, 1'b0);
      do_op(16'h00FF, 16'h0001, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0}, 1'b1);

      // Back-to-back: second start held during the done cycle
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h0003; bus.b = 16'h0004; bus.sub = 1'b0;
      sb.push_back('{16'h0007, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_done", {31'd0, bus.done}, 32'd1);
      bus.start = 1'b1; bus.a = 16'h0010; bus.b = 16'h0001; bus.sub = 1'b1;
      sb.push_back('{16'h000F, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("b2b_done_gap", n, 32'd5);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
